// File: rtl/carry_seg_adder_pkg.sv
// Shared constants and helpers for the segmented carry-chain adder.
// seg_add works on up to SEG_MAX-bit slices; bits above the requested width come back zero.
package carry_seg_adder_pkg;

  localparam string SEL_OPMODE5 = "OPMODE5";
  localparam string SEL_CARRYIN = "CARRYIN";

  localparam int unsigned SEG_MAX = 64;

  function automatic int unsigned calc_width(input int unsigned seg_width,
                                             input int unsigned segments);
    return seg_width * segments;
  endfunction

  // Returns {carry, sum} with the carry at bit w; operands must be zero-extended.
  function automatic logic [SEG_MAX:0] seg_add(input logic [SEG_MAX-1:0] a,
                                               input logic [SEG_MAX-1:0] b,
                                               input logic               c,
                                               input int unsigned        w);
    logic [SEG_MAX:0] full;
    logic [SEG_MAX:0] mask;
    full = {1'b0, a} + {1'b0, b} + (SEG_MAX+1)'(c);
    mask = ((SEG_MAX+1)'(1) << (w + 1)) - (SEG_MAX+1)'(1);
    return full & mask;
  endfunction

endpackage

// File: rtl/carry_seg_adder_stage.sv
// One pipelined slice: operand skew, SEG_WIDTH adder with carry/sum registers, sum deskew.
module carry_seg_stage
  import carry_seg_adder_pkg::*;
#(
  parameter int unsigned SEG_WIDTH = 12,
  parameter int unsigned SEGMENTS  = 4,
  parameter int unsigned IDX       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout
);

  localparam int unsigned SKEW   = IDX;
  localparam int unsigned DESKEW = SEGMENTS - 1 - IDX;
  localparam int unsigned AB_W   = 2 * SEG_WIDTH;

  logic [AB_W-1:0]      ab_sk;
  logic [SEG_MAX:0]     res_c;
  logic [SEG_WIDTH-1:0] sum_q;
  logic                 unused_res;

  // Operand slice k waits k stages for its incoming carry.
  if (SKEW == 0) begin : g_no_skew
    assign ab_sk = {a, b};
  end else begin : g_skew
    logic [AB_W-1:0] ab_q [SKEW];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(SKEW); i++) ab_q[i] <= '0;
      end else if (ce) begin
        ab_q[0] <= {a, b};
        for (int i = 1; i < int'(SKEW); i++) ab_q[i] <= ab_q[i-1];
      end
    end
    assign ab_sk = ab_q[SKEW-1];
  end

  always_comb begin
    res_c = seg_add(SEG_MAX'(ab_sk[AB_W-1:SEG_WIDTH]), SEG_MAX'(ab_sk[SEG_WIDTH-1:0]),
                    cin, SEG_WIDTH);
  end

  assign unused_res = ^res_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cout  <= 1'b0;
    end else if (ce) begin
      sum_q <= res_c[SEG_WIDTH-1:0];
      cout  <= res_c[SEG_WIDTH];
    end
  end

  // Sum of slice k waits for the later slices of the same sample.
  if (DESKEW == 0) begin : g_no_deskew
    assign sum = sum_q;
  end else begin : g_deskew
    logic [SEG_WIDTH-1:0] sum_d [DESKEW];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DESKEW); i++) sum_d[i] <= '0;
      end else if (ce) begin
        sum_d[0] <= sum_q;
        for (int i = 1; i < int'(DESKEW); i++) sum_d[i] <= sum_d[i-1];
      end
    end
    assign sum = sum_d[DESKEW-1];
  end

endmodule

// File: rtl/carry_seg_adder.sv
// Segmented, pipelined post-adder: carry-in select, optional input register stage,
// SEGMENTS carry-chained slices and a matching valid shift register.
module carry_seg_adder
  import carry_seg_adder_pkg::*;
#(
  parameter string       CARRYINSEL = "OPMODE5",
  parameter int unsigned SEG_WIDTH  = 12,
  parameter int unsigned SEGMENTS   = 4,
  parameter int unsigned CARRYINREG = 1,
  localparam int unsigned W         = calc_width(SEG_WIDTH, SEGMENTS)
) (
  input  logic         CLK,
  input  logic         RSTCARRYIN,
  input  logic         CECARRYIN,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         OPMODE5,
  input  logic         CARRYIN,
  input  logic         VALID_IN,
  output logic [W-1:0] P,
  output logic         CARRYOUT,
  output logic         VALID_OUT
);

  localparam int unsigned L = SEGMENTS + ((CARRYINREG != 0) ? 1 : 0);

  logic         cin_c;
  logic         unused_src;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         cin_s;
  logic [SEGMENTS:0] carry;
  logic [L-1:0] vld_q;

  // Carry-in source is fixed at elaboration.
  if (CARRYINSEL == SEL_OPMODE5) begin : g_sel_op5
    assign cin_c = OPMODE5;
  end else if (CARRYINSEL == SEL_CARRYIN) begin : g_sel_cin
    assign cin_c = CARRYIN;
  end else begin : g_sel_zero
    assign cin_c = 1'b0;
  end

  assign unused_src = OPMODE5 ^ CARRYIN;

  if (CARRYINREG != 0) begin : g_inreg
    always_ff @(posedge CLK) begin
      if (RSTCARRYIN) begin
        a_s   <= '0;
        b_s   <= '0;
        cin_s <= 1'b0;
      end else if (CECARRYIN) begin
        a_s   <= A;
        b_s   <= B;
        cin_s <= cin_c;
      end
    end
  end else begin : g_no_inreg
    assign a_s   = A;
    assign b_s   = B;
    assign cin_s = cin_c;
  end

  assign carry[0] = cin_s;

  for (genvar k = 0; k < int'(SEGMENTS); k++) begin : g_seg
    carry_seg_stage #(
      .SEG_WIDTH(SEG_WIDTH),
      .SEGMENTS (SEGMENTS),
      .IDX      (k)
    ) u_stage (
      .clk (CLK),
      .rst (RSTCARRYIN),
      .ce  (CECARRYIN),
      .a   (a_s[k*SEG_WIDTH +: SEG_WIDTH]),
      .b   (b_s[k*SEG_WIDTH +: SEG_WIDTH]),
      .cin (carry[k]),
      .sum (P[k*SEG_WIDTH +: SEG_WIDTH]),
      .cout(carry[k+1])
    );
  end

  assign CARRYOUT = carry[SEGMENTS];

  always_ff @(posedge CLK) begin
    if (RSTCARRYIN) begin
      vld_q <= '0;
    end else if (CECARRYIN) begin
      vld_q <= L'({vld_q, VALID_IN});
    end
  end

  assign VALID_OUT = vld_q[L-1];

endmodule

// File: tb/tb_carry_seg_adder.sv
// Bench for carry_seg_adder: five configurations share one stimulus stream and are
// compared every cycle against a per-configuration latency-delayed arithmetic model.
module tb_carry_seg_adder;

  localparam int NI = 5;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic        v;
    logic [47:0] p;
    logic        co;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [47:0] a;
  logic [47:0] b;
  logic        op5;
  logic        cin;
  logic        vin;
  logic [47:0] p  [NI];
  logic        co [NI];
  logic        vo [NI];

  exp_t pipe [NI][8];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  carry_seg_adder #(.CARRYINSEL("OPMODE5")) u_op5 (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .A(a), .B(b), .OPMODE5(op5),
    .CARRYIN(cin), .VALID_IN(vin), .P(p[0]), .CARRYOUT(co[0]), .VALID_OUT(vo[0]));

  carry_seg_adder #(.CARRYINSEL("CARRYIN")) u_cin (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .A(a), .B(b), .OPMODE5(op5),
    .CARRYIN(cin), .VALID_IN(vin), .P(p[1]), .CARRYOUT(co[1]), .VALID_OUT(vo[1]));

  carry_seg_adder #(.SEG_WIDTH(48), .SEGMENTS(1), .CARRYINREG(0)) u_l1 (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .A(a), .B(b), .OPMODE5(op5),
    .CARRYIN(cin), .VALID_IN(vin), .P(p[2]), .CARRYOUT(co[2]), .VALID_OUT(vo[2]));

  carry_seg_adder #(.SEG_WIDTH(8), .SEGMENTS(6), .CARRYINREG(1)) u_l7 (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .A(a), .B(b), .OPMODE5(op5),
    .CARRYIN(cin), .VALID_IN(vin), .P(p[3]), .CARRYOUT(co[3]), .VALID_OUT(vo[3]));

  carry_seg_adder #(.CARRYINSEL("BOGUS")) u_bogus (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .A(a), .B(b), .OPMODE5(op5),
    .CARRYIN(cin), .VALID_IN(vin), .P(p[4]), .CARRYOUT(co[4]), .VALID_OUT(vo[4]));

  function automatic int lat_of(input int i);
    case (i)
      2:       return 1;
      3:       return 7;
      default: return 5;
    endcase
  endfunction

  function automatic logic cin_of(input int i);
    case (i)
      0, 2, 3: return op5;
      1:       return cin;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs just sampled, then compare all units.
  task automatic tick();
    logic [48:0] s;
    exp_t        e;
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        for (int j = 0; j < 8; j++) pipe[i][j] = '{1'b0, 48'd0, 1'b0};
      end else if (ce) begin
        for (int j = 7; j > 0; j--) pipe[i][j] = pipe[i][j-1];
        s = 49'(a) + 49'(b) + 49'(cin_of(i));
        pipe[i][0] = '{vin, s[47:0], s[48]};
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      e = pipe[i][lat_of(i)-1];
      check($sformatf("u%0d_p", i),  64'(p[i]),  64'(e.p));
      check($sformatf("u%0d_co", i), 64'(co[i]), 64'(e.co));
      check($sformatf("u%0d_vo", i), 64'(vo[i]), 64'(e.v));
    end
  endtask

  task automatic idle(input int n);
    a = '0; b = '0; vin = 1'b0;
    repeat (n) tick();
  endtask

  task automatic rnd_sample();
    a   = {16'($urandom), 32'($urandom)};
    b   = {16'($urandom), 32'($urandom)};
    op5 = 1'($urandom);
    cin = 1'($urandom);
    vin = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; a = '0; b = '0; op5 = 1'b0; cin = 1'b0; vin = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    idle(2);

    // Basic add with explicit expected values.
    a = 48'h0000_0000_0FFF; b = 48'd1; op5 = 1'b0; cin = 1'b0; vin = 1'b1;
    tick();
    idle(4);
    check("basic_p", 64'(p[0]), 64'h1000);
    check("basic_co", 64'(co[0]), 64'd0);
    check("basic_vo", 64'(vo[0]), 64'd1);
    idle(1);
    check("basic_vo_once", 64'(vo[0]), 64'd0);
    idle(3);

    // Full-chain carry and wrap.
    a = ONES; b = '0; op5 = 1'b1; cin = 1'b0; vin = 1'b1;
    tick();
    idle(4);
    check("wrap_p_op5", 64'(p[0]), 64'd0);
    check("wrap_co_op5", 64'(co[0]), 64'd1);
    check("wrap_p_cin", 64'(p[1]), 64'(ONES));
    check("wrap_co_cin", 64'(co[1]), 64'd0);
    check("wrap_p_bogus", 64'(p[4]), 64'(ONES));
    idle(4);

    // Streaming.
    for (int n = 0; n < 20; n++) begin
      rnd_sample();
      tick();
    end
    idle(8);

    // Stall with two samples in flight; inputs wiggle while disabled.
    rnd_sample(); tick();
    rnd_sample(); tick();
    ce = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rnd_sample();
      tick();
    end
    ce = 1'b1;
    idle(8);

    // Reset mid-flight, with a sample presented on the reset edge.
    for (int n = 0; n < 3; n++) begin
      rnd_sample();
      tick();
    end
    rnd_sample();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_p", 64'(p[0]), 64'd0);
    check("rst_vo", 64'(vo[0]), 64'd0);
    idle(8);

    // Random mix of enables, valids, boundary operands and occasional resets.
    for (int n = 0; n < 300; n++) begin
      rnd_sample();
      vin = 1'($urandom);
      case ($urandom_range(0, 7))
        0: begin a = ONES; b = '0; end
        1: begin a = ONES; b = ONES; end
        default: ;
      endcase
      ce  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; ce = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
